// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared state, error, degree and geometry constants for the rotate job scheduler
package rot_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_GEOM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [1:0] DEG_0   = 2'd0;
    localparam logic [1:0] DEG_90  = 2'd1;
    localparam logic [1:0] DEG_180 = 2'd2;
    localparam logic [1:0] DEG_270 = 2'd3;

    // Largest geometry the core address generator can handle.
    localparam logic [15:0] HEIGHT_MAX = 16'h7FFF;
    localparam logic [15:0] WIDTH_MAX  = 16'h3FFF;

    function automatic logic geom_ok(input logic [15:0] h, input logic [15:0] w);
        return (h != 16'd0) && (w != 16'd0) && (h <= HEIGHT_MAX) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/rot_cmd_fifo.sv
// rtl/rot_cmd_fifo.sv - synchronous command FIFO with flush, wrap-bit pointers and occupancy count
module rot_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Flush beats both push and pop so the queue is guaranteed empty after it.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rot_job_sched.sv
// rtl/rot_job_sched.sv - rotate core job scheduler; ROT_SCHED_PERF_EN adds the last-job cycle counter
module rot_job_sched
    import rot_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int PW          = $clog2(DEPTH) + 1
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET,
    input  logic             I_CMD_VALID,
    output logic             O_CMD_READY,
    input  logic [15:0]      I_CMD_HEIGHT,
    input  logic [15:0]      I_CMD_WIDTH,
    input  logic             I_CMD_DIRECTION,
    input  logic [1:0]       I_CMD_DEGREES,
    input  logic [TAG_W-1:0] I_CMD_TAG,
    input  logic             I_FLUSH,
    output logic [15:0]      O_HEIGHT,
    output logic [15:0]      O_WIDTH,
    output logic             O_DIRECTION,
    output logic [1:0]       O_DEGREES,
    output logic             O_START,
    input  logic             I_CORE_BUSY,
    output logic             O_DONE,
    output logic [TAG_W-1:0] O_DONE_TAG,
    output logic [1:0]       O_DONE_ERR,
    output logic             O_IRQ,
    input  logic             I_IRQ_CLR,
    output logic [PW-1:0]    O_PENDING,
    output logic [15:0]      O_JOBS_DONE,
    output logic [31:0]      O_LAST_CYCLES
);

    localparam int CW = 35 + TAG_W;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      head;
    logic               full, empty, pop;
    logic [15:0]        head_h, head_w;
    logic               head_dir;
    logic [1:0]         head_deg;
    logic [TAG_W-1:0]   head_tag;
    logic [TW-1:0]      tmo_q;
    logic               tmo_clr, tmo_inc;
    logic               err_load;
    logic [1:0]         err_d, err_q;
    logic [TAG_W-1:0]   tag_q;

    assign O_CMD_READY = !I_HRESET && !full && !I_FLUSH;
    assign {head_h, head_w, head_dir, head_deg, head_tag} = head;

    rot_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk       (I_HCLK),
        .rst       (I_HRESET),
        .push      (I_CMD_VALID && O_CMD_READY),
        .push_data ({I_CMD_HEIGHT, I_CMD_WIDTH, I_CMD_DIRECTION, I_CMD_DEGREES, I_CMD_TAG}),
        .pop       (pop),
        .flush     (I_FLUSH),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (O_PENDING)
    );

    // State register; async reset drops any in-flight job silently.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        O_START  = 1'b0;
        O_DONE   = 1'b0;
        tmo_clr  = 1'b0;
        tmo_inc  = 1'b0;
        err_load = 1'b0;
        err_d    = ERR_OK;
        case (state_q)
            IDLE: begin
                if (!empty && !I_FLUSH) begin
                    pop = 1'b1;
                    if (geom_ok(head_h, head_w)) begin
                        state_d = LAUNCH;
                    end else begin
                        state_d  = DONE;
                        err_load = 1'b1;
                        err_d    = ERR_GEOM;
                    end
                end
            end
            LAUNCH: begin
                O_START = 1'b1;
                tmo_clr = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (I_CORE_BUSY) begin
                    state_d = RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = DONE;
                    err_load = 1'b1;
                    err_d    = ERR_TIMEOUT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            RUN: begin
                if (!I_CORE_BUSY) begin
                    state_d  = DONE;
                    err_load = 1'b1;
                    err_d    = ERR_OK;
                end
            end
            DONE: begin
                O_DONE  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration and tag latch on pop; held until the next pop.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            O_HEIGHT    <= '0;
            O_WIDTH     <= '0;
            O_DIRECTION <= 1'b0;
            O_DEGREES   <= '0;
            tag_q       <= '0;
        end else if (pop) begin
            O_HEIGHT    <= head_h;
            O_WIDTH     <= head_w;
            O_DIRECTION <= head_dir;
            O_DEGREES   <= head_deg;
            tag_q       <= head_tag;
        end
    end

    // Busy-rise timeout counter.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET)     tmo_q <= '0;
        else if (tmo_clr) tmo_q <= '0;
        else if (tmo_inc) tmo_q <= tmo_q + 1'b1;
    end

    // Completion error code, captured on the transition into DONE.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET)      err_q <= ERR_OK;
        else if (err_load) err_q <= err_d;
    end

    assign O_DONE_TAG = tag_q;
    assign O_DONE_ERR = err_q;

    // Sticky interrupt (set beats clear) and wrapping completion counter.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            O_IRQ       <= 1'b0;
            O_JOBS_DONE <= '0;
        end else begin
            if (O_DONE)         O_IRQ <= 1'b1;
            else if (I_IRQ_CLR) O_IRQ <= 1'b0;
            if (O_DONE) O_JOBS_DONE <= O_JOBS_DONE + 16'd1;
        end
    end

`ifdef ROT_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] last_cycles;

    // Saturating cycle count from start until the core finishes.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET)
            perf_cnt <= '0;
        else if (state_q == LAUNCH)
            perf_cnt <= '0;
        else if ((state_q == WAIT_BUSY || state_q == RUN) && perf_cnt != 32'hFFFF_FFFF)
            perf_cnt <= perf_cnt + 32'd1;
    end

    // Only successful jobs publish their cycle count.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET)                       last_cycles <= '0;
        else if (O_DONE && err_q == ERR_OK) last_cycles <= perf_cnt;
    end

    assign O_LAST_CYCLES = last_cycles;
`else
    assign O_LAST_CYCLES = '0;
`endif

endmodule
